// File: rtl/bounce_shifter.sv
// One-hot LED position generator: bounce (with dwell at bit 0), rotate left, rotate right, hold.
// Latency: pos/count/dir/wrap are registered and change together on the step edge; no extra pipeline stage.
// Backpressure: none; enable=0 freezes the prescaler and every output, and resumes without losing a step.
module bounce_shifter #(
  parameter int WIDTH    = 8,
  parameter int DWELL    = 4,
  parameter int PRESCALE = 1,
  localparam int PW      = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic [PW-1:0]    pos,
  output logic             dir,
  output logic             wrap
);

  // Prescaler counter width; a PRESCALE of 1 still needs a 1-bit counter that simply stays at 0.
  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PSW-1:0] PRESC_LAST = PSW'(PRESCALE - 1);
  localparam logic [PW-1:0]  POS_TOP    = PW'(WIDTH - 1);
  localparam logic [PW-1:0]  POS_TURN   = PW'((WIDTH > 2) ? (WIDTH - 2) : 0);
  localparam logic [PW-1:0]  POS_ONE    = PW'(1);
  localparam logic [7:0]     DWELL_LAST = 8'(DWELL - 1);

  localparam logic [1:0] MODE_BOUNCE = 2'b00;
  localparam logic [1:0] MODE_ROTL   = 2'b01;
  localparam logic [1:0] MODE_ROTR   = 2'b10;

  typedef enum logic [1:0] {
    ST_DWELL = 2'd0,
    ST_RISE  = 2'd1,
    ST_FALL  = 2'd2
  } bstate_t;

  // Registered state
  bstate_t          state_q;
  logic             in_bounce_q;  // bounce state/dwell_cnt are meaningful (cleared by rotate, kept by hold)
  logic [7:0]       dwell_q;
  logic [PSW-1:0]   presc_q;
  logic [PW-1:0]    pos_q;
  logic [WIDTH-1:0] count_q;
  logic             dir_q;
  logic             wrap_q;

  // Next-state values
  bstate_t          state_d;
  logic             in_bounce_d;
  logic [7:0]       dwell_d;
  logic [PSW-1:0]   presc_d;
  logic [PW-1:0]    pos_d;
  logic [WIDTH-1:0] count_d;
  logic             dir_d;
  logic             wrap_d;

  // Helpers
  logic             step;
  bstate_t          eff_state;  // bounce state to act on this step, after the re-entry rule
  logic [7:0]       eff_dwell;

  // Prescaler, bounce FSM and rotate next-state logic.
  always_comb begin
    step        = enable && (presc_q == PRESC_LAST);
    presc_d     = presc_q;
    state_d     = state_q;
    in_bounce_d = in_bounce_q;
    dwell_d     = dwell_q;
    pos_d       = pos_q;
    dir_d       = dir_q;
    wrap_d      = 1'b0;
    count_d     = '0;

    // On re-entry from a rotate, the old bounce context is gone: start in
    // DWELL if sitting on bit 0, otherwise pick up the climb from here.
    eff_state = in_bounce_q ? state_q : ((pos_q == '0) ? ST_DWELL : ST_RISE);
    eff_dwell = in_bounce_q ? dwell_q : 8'd0;

    if (enable) begin
      presc_d = step ? '0 : presc_q + 1'b1;
    end

    if (step) begin
      case (mode)
        MODE_BOUNCE: begin
          in_bounce_d = 1'b1;
          case (eff_state)
            ST_DWELL: begin
              dir_d = 1'b0;
              if (eff_dwell == DWELL_LAST) begin
                state_d = ST_RISE;
                pos_d   = POS_ONE;
                dwell_d = 8'd0;
              end else begin
                state_d = ST_DWELL;
                dwell_d = eff_dwell + 8'd1;
              end
            end
            ST_RISE: begin
              dwell_d = eff_dwell;
              if (pos_q == POS_TOP) begin
                if (WIDTH > 2) begin
                  state_d = ST_FALL;
                  pos_d   = POS_TURN;
                  dir_d   = 1'b1;
                end else begin
                  // Two-bit bus: there is no descent, the top goes straight back to the dwell.
                  state_d = ST_DWELL;
                  pos_d   = '0;
                  dwell_d = 8'd0;
                  dir_d   = 1'b0;
                  wrap_d  = 1'b1;
                end
              end else begin
                state_d = ST_RISE;
                pos_d   = pos_q + 1'b1;
                dir_d   = 1'b0;
              end
            end
            ST_FALL: begin
              dwell_d = eff_dwell;
              if (pos_q == POS_ONE) begin
                state_d = ST_DWELL;
                pos_d   = '0;
                dwell_d = 8'd0;
                dir_d   = 1'b0;
                wrap_d  = 1'b1;
              end else begin
                state_d = ST_FALL;
                pos_d   = pos_q - 1'b1;
                dir_d   = 1'b1;
              end
            end
            default: begin
              state_d = ST_DWELL;
              pos_d   = '0;
              dwell_d = 8'd0;
              dir_d   = 1'b0;
            end
          endcase
        end
        MODE_ROTL: begin
          in_bounce_d = 1'b0;
          dir_d       = 1'b0;
          if (pos_q == POS_TOP) begin
            pos_d  = '0;
            wrap_d = 1'b1;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end
        MODE_ROTR: begin
          in_bounce_d = 1'b0;
          dir_d       = 1'b1;
          if (pos_q == '0) begin
            pos_d  = POS_TOP;
            wrap_d = 1'b1;
          end else begin
            pos_d = pos_q - 1'b1;
          end
        end
        default: begin
          // Hold: the step is consumed, nothing moves and the bounce context is kept.
        end
      endcase
    end

    count_d[pos_d] = 1'b1;
  end

  // State register with synchronous active-low reset; reset beats a coincident step.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_DWELL;
      in_bounce_q <= 1'b1;
      dwell_q     <= 8'd0;
      presc_q     <= '0;
      pos_q       <= '0;
      count_q     <= WIDTH'(1);
      dir_q       <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_bounce_q <= in_bounce_d;
      dwell_q     <= dwell_d;
      presc_q     <= presc_d;
      pos_q       <= pos_d;
      count_q     <= count_d;
      dir_q       <= dir_d;
      wrap_q      <= wrap_d;
    end
  end

  assign count = count_q;
  assign pos   = pos_q;
  assign dir   = dir_q;
  // The pulse is masked while paused so a wrap is never reported on a frozen cycle.
  assign wrap  = wrap_q & enable;

endmodule

// File: tb/tb_bounce_shifter.sv
// Bench for bounce_shifter: three instances (8-bit default, 8-bit prescale 3, 2-bit minimum).
// A phase-table reference model is compared on every cycle, plus directed pattern checks.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_bounce_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] mode;
  logic       en0, en1, en2;

  logic [7:0] c0; logic [2:0] p0; logic d0, w0;
  logic [7:0] c1; logic [2:0] p1; logic d1, w1;
  logic [1:0] c2; logic [0:0] p2; logic d2, w2;

  bounce_shifter #(.WIDTH(8), .DWELL(4), .PRESCALE(1)) u0 (
    .clk(clk), .reset(reset), .enable(en0), .mode(mode),
    .count(c0), .pos(p0), .dir(d0), .wrap(w0));
  bounce_shifter #(.WIDTH(8), .DWELL(4), .PRESCALE(3)) u1 (
    .clk(clk), .reset(reset), .enable(en1), .mode(mode),
    .count(c1), .pos(p1), .dir(d1), .wrap(w1));
  bounce_shifter #(.WIDTH(2), .DWELL(1), .PRESCALE(1)) u2 (
    .clk(clk), .reset(reset), .enable(en2), .mode(mode),
    .count(c2), .pos(p2), .dir(d2), .wrap(w2));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, one slot per instance.
  int mW[3] = '{8, 8, 2};
  int mD[3] = '{4, 4, 1};
  int mP[3] = '{1, 3, 1};
  int m_pos[3], m_phase[3], m_presc[3];
  bit m_valid[3], m_dir[3], m_wrap[3];

  // Lit bit at phase k of a bounce period: D dwell slots, climb 1..w-1, descend w-2..1.
  function automatic int seq_pos(int w, int d, int k);
    if (k < d) return 0;
    k = k - d;
    if (k < w - 1) return k + 1;
    k = k - (w - 1);
    return w - 2 - k;
  endfunction

  task automatic model_edge(int i, bit e);
    int per;
    if (!reset) begin
      m_pos[i] = 0; m_phase[i] = 0; m_presc[i] = 0;
      m_valid[i] = 1'b1; m_dir[i] = 1'b0; m_wrap[i] = 1'b0;
      return;
    end
    m_wrap[i] = 1'b0;
    if (!e) return;
    if (m_presc[i] != mP[i] - 1) begin
      m_presc[i]++;
      return;
    end
    m_presc[i] = 0;
    per = mD[i] + 2 * mW[i] - 3;
    case (mode)
      2'b00: begin
        if (!m_valid[i]) begin
          m_phase[i] = (m_pos[i] == 0) ? 0 : mD[i] + m_pos[i] - 1;
          m_valid[i] = 1'b1;
        end
        m_phase[i] = (m_phase[i] + 1) % per;
        m_wrap[i]  = (m_phase[i] == 0);
        m_pos[i]   = seq_pos(mW[i], mD[i], m_phase[i]);
        m_dir[i]   = (m_phase[i] >= mD[i] + mW[i] - 1);
      end
      2'b01: begin
        m_wrap[i]  = (m_pos[i] == mW[i] - 1);
        m_pos[i]   = (m_pos[i] + 1) % mW[i];
        m_dir[i]   = 1'b0;
        m_valid[i] = 1'b0;
      end
      2'b10: begin
        m_wrap[i]  = (m_pos[i] == 0);
        m_pos[i]   = (m_pos[i] + mW[i] - 1) % mW[i];
        m_dir[i]   = 1'b1;
        m_valid[i] = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(string tag);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", tag);
  endtask

  task automatic compare_all();
    check("u0_count", 64'(c0), 64'(1) << m_pos[0]);
    check("u0_pos",   64'(p0), 64'(m_pos[0]));
    check("u0_dir",   64'(d0), 64'(m_dir[0]));
    check("u0_wrap",  64'(w0), 64'(m_wrap[0] & en0));
    check("u1_count", 64'(c1), 64'(1) << m_pos[1]);
    check("u1_pos",   64'(p1), 64'(m_pos[1]));
    check("u1_dir",   64'(d1), 64'(m_dir[1]));
    check("u1_wrap",  64'(w1), 64'(m_wrap[1] & en1));
    check("u2_count", 64'(c2), 64'(1) << m_pos[2]);
    check("u2_pos",   64'(p2), 64'(m_pos[2]));
    check("u2_dir",   64'(d2), 64'(m_dir[2]));
    check("u2_wrap",  64'(w2), 64'(m_wrap[2] & en2));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(0, en0);
    model_edge(1, en1);
    model_edge(2, en2);
    @(negedge clk);
    compare_all();
  endtask

  logic [7:0] tbl [17] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                           8'h40, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};

  initial begin
    int guard;
    reset = 1'b0; mode = 2'b00; en0 = 1'b1; en1 = 1'b1; en2 = 1'b1;
    @(negedge clk);

    // Reset state
    tick(); tick();
    check("rst_count", 64'(c0), 64'h01);
    check("rst_pos",   64'(p0), 64'h0);
    check("rst_dir",   64'(d0), 64'h0);
    check("rst_wrap",  64'(w0), 64'h0);

    // Bounce with defaults, prescale 3 and the 2-bit minimum, all from the same release
    reset = 1'b1;
    for (int i = 1; i <= 34; i++) begin
      tick();
      check("bounce_seq",  64'(c0), 64'(tbl[i % 17]));
      check("bounce_wrap", 64'(w0), 64'((i % 17) == 0));
      check("bounce_dir",  64'(d0), 64'((i % 17) >= 11));
      check("presc_seq",   64'(c1), 64'(tbl[(i / 3) % 17]));
      check("w2_seq",      64'(c2), (i % 2) ? 64'h2 : 64'h1);
      check("w2_wrap",     64'(w2), 64'((i % 2) == 0));
    end

    // Pause the prescaled instance partway through its hold of 0x10 on the climb
    guard = 0;
    while (!(m_pos[1] == 4 && !m_dir[1] && m_presc[1] == 1) && guard < 200) begin
      tick(); guard++;
    end
    if (guard >= 200) timeout("wait_u1_0x10");
    en1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("pause_count", 64'(c1), 64'h10);
      check("pause_wrap",  64'(w1), 64'h0);
    end
    en1 = 1'b1;
    tick();
    check("resume_hold", 64'(c1), 64'h10);
    tick();
    check("resume_step", 64'(c1), 64'h20);

    // Rotate left from reset
    reset = 1'b0; tick();
    reset = 1'b1; mode = 2'b01;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("rotl_count", 64'(c0), 64'(1) << (i % 8));
      check("rotl_wrap",  64'(w0), 64'((i % 8) == 0));
    end

    // Rotate right from reset
    reset = 1'b0; tick();
    reset = 1'b1; mode = 2'b10;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("rotr_count", 64'(c0), 64'(1) << ((8 - (i % 8)) % 8));
      check("rotr_wrap",  64'(w0), 64'(i == 1 || i == 9));
      check("rotr_dir",   64'(d0), 64'h1);
    end

    // Hold during the descent at 0x08, then resume bouncing
    reset = 1'b0; tick();
    reset = 1'b1; mode = 2'b00;
    guard = 0;
    while (!(m_pos[0] == 3 && m_dir[0]) && guard < 100) begin
      tick(); guard++;
    end
    if (guard >= 100) timeout("wait_fall_0x08");
    mode = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_count", 64'(c0), 64'h08);
      check("hold_dir",   64'(d0), 64'h1);
    end
    mode = 2'b00;
    tick(); check("unhold_04", 64'(c0), 64'h04);
    tick(); check("unhold_02", 64'(c0), 64'h02);
    tick(); check("unhold_01", 64'(c0), 64'h01);
    check("unhold_wrap", 64'(w0), 64'h1);

    // Rotate left to pos 5, then switch to bounce: climb continues
    reset = 1'b0; tick();
    reset = 1'b1; mode = 2'b01;
    for (int i = 0; i < 5; i++) tick();
    check("rotl_pos5", 64'(p0), 64'h5);
    mode = 2'b00;
    tick(); check("reenter_pos6", 64'(p0), 64'h6); check("reenter_dir", 64'(d0), 64'h0);
    tick(); check("reenter_pos7", 64'(p0), 64'h7);
    tick(); check("reenter_fall", 64'(p0), 64'h6); check("reenter_fdir", 64'(d0), 64'h1);

    // Reset in the middle of a prescaled hold of 0x20 on the climb
    reset = 1'b0; tick();
    reset = 1'b1;
    guard = 0;
    while (!(m_pos[1] == 5 && !m_dir[1] && m_presc[1] != 0) && guard < 200) begin
      tick(); guard++;
    end
    if (guard >= 200) timeout("wait_u1_0x20");
    reset = 1'b0;
    tick();
    check("midrst_count", 64'(c1), 64'h01);
    check("midrst_pos",   64'(p1), 64'h0);
    check("midrst_dir",   64'(d1), 64'h0);
    check("midrst_wrap",  64'(w1), 64'h0);
    reset = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("midrst_dwell", 64'(c1), (i < 12) ? 64'h01 : 64'h02);
    end

    // Randomised mix of modes, pauses and occasional resets
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      en0 = ($urandom_range(0, 7) != 0);
      en1 = ($urandom_range(0, 7) != 0);
      en2 = ($urandom_range(0, 7) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
